// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
package mdu_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 1;

  localparam logic [1:0] DIV_OP_SIGNED   = 2'b10;
  localparam logic [1:0] DIV_OP_UNSIGNED = 2'b01;
  localparam logic [1:0] DIV_OP_NONE     = 2'b00;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_FIX
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic             qbit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // The shifted remainder needs one extra bit: with a divisor above 2^(WIDTH-1)
  // the running remainder can overflow WIDTH bits before the subtraction.
  assign w_shift  = {rem, dvd_msb};
  assign w_diff   = w_shift - {1'b0, dvs};
  assign qbit     = (w_shift >= {1'b0, dvs});
  assign rem_next = qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/ex_div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU; result = {remainder, quotient}.
// Define EX_DIV_ZERO_FAST_EN to finish divide-by-zero in one cycle instead of WIDTH+1.
module ex_div_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         div_op,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] result,
  output logic               done
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t         r_state;
  div_state_t         w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvs;
  logic               r_q_neg;
  logic               r_r_neg;
  logic [2*WIDTH-1:0] r_result;

  logic               w_accept;
  logic               w_signed;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_abs_dvd;
  logic [WIDTH-1:0]   w_abs_dvs;
  logic               w_zero_fast;
  logic               w_last;
  logic [WIDTH-1:0]   w_rem_next;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;

  assign w_accept  = (r_state == DIV_IDLE) &&
                     ((div_op == DIV_OP_SIGNED) || (div_op == DIV_OP_UNSIGNED));
  assign w_signed  = (div_op == DIV_OP_SIGNED);
  assign w_sa      = w_signed & dividend[WIDTH-1];
  assign w_sb      = w_signed & divisor[WIDTH-1];
  assign w_abs_dvd = w_sa ? (~dividend + 1'b1) : dividend;
  assign w_abs_dvs = w_sb ? (~divisor + 1'b1) : divisor;
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef EX_DIV_ZERO_FAST_EN
  assign w_zero_fast = (divisor == '0);
`else
  assign w_zero_fast = 1'b0;
`endif

  // Quotient bits shift into the low end of r_quo as dividend bits leave the top.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (r_rem),
    .dvd_msb  (r_quo[WIDTH-1]),
    .dvs      (r_dvs),
    .rem_next (w_rem_next),
    .qbit     (w_qbit)
  );

  assign w_q_fix = r_q_neg ? (~r_quo + 1'b1) : r_quo;
  assign w_r_fix = r_r_neg ? (~r_rem + 1'b1) : r_rem;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= DIV_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: next-state gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      DIV_IDLE: if (w_accept) w_state_next = w_zero_fast ? DIV_FIX : DIV_BUSY;
      DIV_BUSY: if (w_last)   w_state_next = DIV_FIX;
      DIV_FIX:                w_state_next = DIV_IDLE;
      default:                w_state_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        DIV_IDLE: begin
          if (w_accept) begin
            r_cnt   <= '0;
            r_dvs   <= w_abs_dvs;
            r_q_neg <= w_sa ^ w_sb;
            r_r_neg <= w_sa;
            // Fast zero path preloads what WIDTH steps against a zero divisor would produce.
            if (w_zero_fast) begin
              r_rem <= w_abs_dvd;
              r_quo <= '1;
            end else begin
              r_rem <= '0;
              r_quo <= w_abs_dvd;
            end
          end
        end
        DIV_BUSY: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt + 1'b1;
        end
        DIV_FIX: r_result <= {w_r_fix, w_q_fix};
        default: ;
      endcase
    end
  end

  assign done   = (r_state == DIV_IDLE);
  assign result = r_result;

endmodule
